// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues single-word reads to instruction memory and
//   buffers returned words with their PC in a 2-entry in-order FIFO for decode.
// Latency: first IMEM_REQ the cycle after RESET drops; INSTR_VALID rises the cycle after IMEM_VALID.
// Backpressure: STALL holds the FIFO head; with two entries buffered no new request is issued.
//
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   IMEM_REQ/IMEM_ADDR    - one-cycle read request and word address
//   IMEM_VALID/IMEM_RDATA - read response (one or more cycles after the request)
//   STALL                 - decode not ready; head is held
//   BRANCH_TAKEN/_TARGET  - redirect fetch and flush buffered words
//   WRONG_OP_CODE         - illegal head instruction; vector to EXC_VECTOR, record EPC
//   INSTR_VALID/INSTR/OP_CODE/FUNC_CODE/INSTR_PC - FIFO head presentation
//   EPC                   - PC of the last faulting instruction
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'hFFF0
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic        IMEM_VALID,
    input  logic [15:0] IMEM_RDATA,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [15:0] BRANCH_TARGET,
    input  logic        WRONG_OP_CODE,
    output logic        INSTR_VALID,
    output logic [15:0] INSTR,
    output logic [3:0]  OP_CODE,
    output logic [3:0]  FUNC_CODE,
    output logic [15:0] INSTR_PC,
    output logic [15:0] EPC
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;        // next address to fetch
    logic [15:0] r_req_addr;  // address of the request currently outstanding
    logic [15:0] r_epc;
    logic [15:0] r_instr [2];
    logic [15:0] r_ipc   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic w_valid;
    logic w_exc;
    logic w_redirect;
    logic w_issue;
    logic w_push;
    logic w_pop;

    // Head is hidden while RESET is high so nothing leaks out before the first reset edge.
    assign w_valid    = (r_count != 2'd0) && !RESET;
    assign w_exc      = WRONG_OP_CODE && w_valid;
    assign w_redirect = w_exc || BRANCH_TAKEN;
    // A redirect cycle issues nothing: the fetch PC is about to change.
    assign w_issue    = (r_state == S_REQ) && (r_count != 2'd2) && !w_redirect && !RESET;
    // A response arriving with a redirect belongs to the old stream and is dropped.
    assign w_push     = (r_state == S_WAIT) && IMEM_VALID && !w_redirect;
    assign w_pop      = w_valid && !STALL && !w_redirect;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_epc      <= 16'h0000;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            // Fetch PC: exception beats branch beats sequential advance.
            if (w_exc) begin
                r_pc  <= EXC_VECTOR;
                r_epc <= r_ipc[r_rd_ptr];
            end else if (BRANCH_TAKEN) begin
                r_pc <= BRANCH_TARGET;
            end else if (w_issue) begin
                r_pc       <= r_pc + 16'd1;
                r_req_addr <= r_pc;
            end

            if (w_push) begin
                r_instr[r_wr_ptr] <= IMEM_RDATA;
                r_ipc[r_wr_ptr]   <= r_req_addr;
            end

            // A flush overrides any same-cycle push or pop.
            if (w_redirect) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end

            case (r_state)
                S_REQ: begin
                    if (w_issue) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (IMEM_VALID)      r_state <= S_REQ;
                    else if (w_redirect) r_state <= S_DISCARD;
                end
                S_DISCARD: begin
                    // The stale response closes out the old request even when another
                    // redirect lands in the same cycle; waiting longer would never end.
                    if (IMEM_VALID) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign IMEM_REQ    = w_issue;
    assign IMEM_ADDR   = r_pc;
    assign INSTR_VALID = w_valid;
    assign INSTR       = r_instr[r_rd_ptr];
    assign OP_CODE     = r_instr[r_rd_ptr][15:12];
    assign FUNC_CODE   = r_instr[r_rd_ptr][3:0];
    assign INSTR_PC    = r_ipc[r_rd_ptr];
    assign EPC         = r_epc;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: the fetch address loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 16'hFFF0: the fetch address loaded on an illegal-opcode exception.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port IMEM_REQ, output, 1 bit: one-cycle instruction-memory read request.
REQ-006 SHALL have port IMEM_ADDR, output, 16 bits: word address for IMEM_REQ.
REQ-007 SHALL have port IMEM_VALID, input, 1 bit: read data returned; arrives one or more cycles after IMEM_REQ.
REQ-008 SHALL have port IMEM_RDATA, input, 16 bits: instruction word, valid with IMEM_VALID.
REQ-009 SHALL have port STALL, input, 1 bit: decode stage not ready.
REQ-010 SHALL have port BRANCH_TAKEN, input, 1 bit: redirect request.
REQ-011 SHALL have port BRANCH_TARGET, input, 16 bits: redirect address.
REQ-012 SHALL have port WRONG_OP_CODE, input, 1 bit: control-unit illegal-instruction flag for the current INSTR.
REQ-013 SHALL have port INSTR_VALID, output, 1 bit: INSTR, OP_CODE, FUNC_CODE and INSTR_PC are valid.
REQ-014 SHALL have port INSTR, output, 16 bits: head instruction word.
REQ-015 SHALL have port OP_CODE, output, 4 bits: equal to INSTR[15:12].
REQ-016 SHALL have port FUNC_CODE, output, 4 bits: equal to INSTR[3:0].
REQ-017 SHALL have port INSTR_PC, output, 16 bits: fetch address of INSTR.
REQ-018 SHALL have port EPC, output, 16 bits: INSTR_PC of the last faulting instruction.

Function
REQ-019 SHALL buffer fetched instructions in a 2-entry in-order FIFO of {instruction, PC}; outputs SHALL present the FIFO head; INSTR_VALID SHALL equal FIFO not empty.
REQ-020 SHALL run FSM states REQ, WAIT and DISCARD, with at most one memory request outstanding.
REQ-021 REQ state: IMEM_REQ SHALL be 1 iff FIFO count < 2, with IMEM_ADDR = fetch PC; on issue, fetch PC +1 (16'hFFFF wraps to 16'h0000) and next state WAIT; if FIFO is full, SHALL hold in REQ with IMEM_REQ = 0.
REQ-022 WAIT state: on IMEM_VALID, SHALL push {IMEM_RDATA, address of request} and go to REQ; INSTR_VALID SHALL rise the cycle after IMEM_VALID when FIFO was empty.
REQ-023 Consume: INSTR_VALID=1 and STALL=0 at an edge SHALL pop the head; simultaneous push and pop SHALL leave count unchanged.
REQ-024 Exception: WRONG_OP_CODE=1 with INSTR_VALID=1 SHALL set EPC <= INSTR_PC, fetch PC <= EXC_VECTOR, and flush FIFO; WRONG_OP_CODE with INSTR_VALID=0 SHALL be ignored.
REQ-025 Branch: BRANCH_TAKEN=1 SHALL set fetch PC <= BRANCH_TARGET and flush FIFO; a valid WRONG_OP_CODE in the same cycle SHALL take priority.
REQ-026 Redirect (REQ-024/025) state rules: in REQ, stay in REQ with no issue that cycle; in WAIT without IMEM_VALID, go to DISCARD; in WAIT with IMEM_VALID, drop the data and go to REQ; in DISCARD, update PC and stay in DISCARD.
REQ-027 DISCARD state: SHALL issue no request, drop data on IMEM_VALID, and go to REQ; a flush SHALL override any same-cycle push or pop.

Reset
REQ-028 RESET=1 at an edge SHALL set fetch PC=RESET_PC, FIFO empty, state REQ, and EPC=16'h0000.
REQ-029 While RESET=1, IMEM_REQ and INSTR_VALID SHALL be 0; reset mid-request SHALL abandon the outstanding response.
REQ-030 The first IMEM_REQ (IMEM_ADDR=RESET_PC) SHALL occur in the first cycle after RESET deasserts.

Verification
REQ-031 Streaming: 1-cycle memory returns 16'h0123, 16'h4567; STALL=0 -> IMEM_ADDR 0,1,2...; INSTR_VALID rises 2 cycles after reset release with OP_CODE=0, FUNC_CODE=3, INSTR_PC=0.
REQ-032 Backpressure: STALL=1 held -> after 2 pushes, IMEM_REQ=0 and INSTR_PC stays 0; release STALL -> entries PC 0 then 1 in order, no loss or duplication.
REQ-033 Branch during WAIT: BRANCH_TAKEN with BRANCH_TARGET=16'h0040 while a response is pending -> late response dropped; next IMEM_ADDR=16'h0040; first INSTR_PC after the redirect = 16'h0040.
REQ-034 Exception: WRONG_OP_CODE=1 on INSTR_PC=16'h0005 with simultaneous BRANCH_TAKEN -> EPC=16'h0005; next IMEM_ADDR=16'hFFF0; FIFO flushed.
REQ-035 Wrap and reset: fetch from 16'hFFFF -> next IMEM_ADDR=16'h0000; RESET asserted in WAIT -> INSTR_VALID=0; stale IMEM_VALID ignored; refetch from RESET_PC.
